// File: rtl/lift8_controller_if.sv
`default_nettype none
// ============================================================================
// Module  : lift8_controller_if
// Brief   : Call-button / motor-door bundle for the 8-floor lift controller.
// Revision: 1.0  initial release
// ============================================================================
interface lift8_controller_if;
    logic [2:0] req_floor;
    logic       emergency_stop;
    logic [2:0] current_floor;
    logic [7:0] requests;
    logic [2:0] max_request;
    logic [2:0] min_request;
    logic [1:0] idle;
    logic [1:0] door;
    logic [1:0] Up;
    logic [1:0] Down;

    modport master (
        output req_floor, emergency_stop,
        input  current_floor, requests, max_request, min_request,
        input  idle, door, Up, Down
    );

    modport slave (
        input  req_floor, emergency_stop,
        output current_floor, requests, max_request, min_request,
        output idle, door, Up, Down
    );
endinterface
`default_nettype wire

// File: rtl/lift8_controller.sv
`default_nettype none
// ============================================================================
// Module  : lift8_controller
// Brief   : 8-floor single-car SCAN elevator controller with emergency halt.
// Revision: 1.0  initial release
// ============================================================================
module lift8_controller #(
    parameter int DOOR_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    lift8_controller_if.slave    bus
);
    localparam int c_timer_w = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [c_timer_w-1:0] c_door_load = c_timer_w'(DOOR_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_MOVE_UP   = 3'd1,
        ST_MOVE_DOWN = 3'd2,
        ST_DOOR_OPEN = 3'd3,
        ST_EMERGENCY = 3'd4
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [2:0]           r_floor, w_floor_nxt;
    logic [7:0]           r_requests;
    logic [c_timer_w-1:0] r_timer, w_timer_nxt;
    logic                 r_dir_up, w_dir_up_nxt;

    logic [2:0] w_max, w_min, w_floor_up, w_floor_dn;
    logic       w_above, w_below, w_req_known, w_latch_block;
    logic [7:0] w_set, w_clear;

    always_comb begin
        w_max = r_floor;
        w_min = r_floor;
        for (int i = 0; i < 8; i++)
            if (r_requests[i]) w_max = 3'(i);
        for (int i = 7; i >= 0; i--)
            if (r_requests[i]) w_min = 3'(i);
    end

    assign w_above    = (w_max > r_floor);
    assign w_below    = (w_min < r_floor);
    assign w_floor_up = r_floor + 3'd1;
    assign w_floor_dn = r_floor - 3'd1;

    // A press at the floor where the car already stands (door open or about
    // to open) is served immediately and never becomes a pending request.
    assign w_req_known   = !$isunknown(bus.req_floor);
    assign w_latch_block = (bus.req_floor == r_floor) &&
                           (r_state == ST_IDLE || r_state == ST_DOOR_OPEN);
    assign w_set         = (w_req_known && !w_latch_block) ? (8'b1 << bus.req_floor) : 8'b0;

    always_comb begin
        w_state_nxt  = r_state;
        w_floor_nxt  = r_floor;
        w_timer_nxt  = r_timer;
        w_dir_up_nxt = r_dir_up;
        w_clear      = 8'b0;
        if (bus.emergency_stop) begin
            w_state_nxt = ST_EMERGENCY;
            w_timer_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if ((w_req_known && bus.req_floor == r_floor) || r_requests[r_floor]) begin
                        w_state_nxt = ST_DOOR_OPEN;
                        w_timer_nxt = c_door_load;
                        w_clear     = 8'b1 << r_floor;
                    end else if (w_above) begin
                        w_state_nxt  = ST_MOVE_UP;
                        w_dir_up_nxt = 1'b1;
                    end else if (w_below) begin
                        w_state_nxt  = ST_MOVE_DOWN;
                        w_dir_up_nxt = 1'b0;
                    end
                end
                ST_MOVE_UP: begin
                    if (w_above) begin
                        w_floor_nxt = w_floor_up;
                        if (r_requests[w_floor_up]) begin
                            w_state_nxt = ST_DOOR_OPEN;
                            w_timer_nxt = c_door_load;
                            w_clear     = 8'b1 << w_floor_up;
                        end
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_MOVE_DOWN: begin
                    if (w_below) begin
                        w_floor_nxt = w_floor_dn;
                        if (r_requests[w_floor_dn]) begin
                            w_state_nxt = ST_DOOR_OPEN;
                            w_timer_nxt = c_door_load;
                            w_clear     = 8'b1 << w_floor_dn;
                        end
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_DOOR_OPEN: begin
                    if (r_timer != '0) begin
                        w_timer_nxt = r_timer - 1'b1;
                    end else if (r_dir_up ? w_above : w_below) begin
                        w_state_nxt = r_dir_up ? ST_MOVE_UP : ST_MOVE_DOWN;
                    end else if (r_dir_up ? w_below : w_above) begin
                        w_state_nxt  = r_dir_up ? ST_MOVE_DOWN : ST_MOVE_UP;
                        w_dir_up_nxt = !r_dir_up;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_EMERGENCY: w_state_nxt = ST_IDLE;
                default:      w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_floor    <= 3'd0;
            r_requests <= 8'b0;
            r_timer    <= '0;
            r_dir_up   <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_floor    <= w_floor_nxt;
            // Clearing wins over a same-edge press at the floor being served.
            r_requests <= (r_requests | w_set) & ~w_clear;
            r_timer    <= w_timer_nxt;
            r_dir_up   <= w_dir_up_nxt;
        end
    end

    logic w_emg;
    assign w_emg = (r_state == ST_EMERGENCY);

    assign bus.current_floor = r_floor;
    assign bus.requests      = r_requests;
    assign bus.max_request   = w_max;
    assign bus.min_request   = w_min;
    assign bus.idle          = {w_emg, r_state == ST_IDLE};
    assign bus.door          = {w_emg, r_state == ST_DOOR_OPEN};
    assign bus.Up            = {w_emg, r_state == ST_MOVE_UP};
    assign bus.Down          = {w_emg, r_state == ST_MOVE_DOWN};
endmodule
`default_nettype wire

// File: tb/tb_lift8_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_lift8_controller
// Brief   : Random-stimulus bench for lift8_controller against a SCAN model.
// Revision: 1.0  initial release
// ============================================================================
module tb_lift8_controller;
    localparam int DC       = 2;
    localparam int N_CYCLES = 3000;

    logic clk = 1'b0;
    logic reset;
    int   cyc;

    lift8_controller_if bus();

    lift8_controller #(.DOOR_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: mode is one of idle/move/door/halt, dir is +1 or -1.
    string m_mode;
    int    m_floor;
    int    m_dir;
    int    m_door_left;
    bit    m_pend[8];
    int    emg_left;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    endtask

    function automatic bit ahead(input int from, input int d);
        for (int f = 0; f < 8; f++)
            if (m_pend[f] && (f - from) * d > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step(input bit rst, input int req, input bit stop);
        bit nxt[8];
        if (rst) begin
            m_mode = "idle"; m_floor = 0; m_dir = 1; m_door_left = 0;
            for (int f = 0; f < 8; f++) m_pend[f] = 1'b0;
            return;
        end
        nxt = m_pend;
        if (!(req == m_floor && (m_mode == "idle" || m_mode == "door")))
            nxt[req] = 1'b1;
        if (stop) begin
            m_mode = "halt";
            m_door_left = 0;
        end else if (m_mode == "halt") begin
            m_mode = "idle";
        end else if (m_mode == "idle") begin
            if (req == m_floor || m_pend[m_floor]) begin
                m_mode = "door"; m_door_left = DC; nxt[m_floor] = 1'b0;
            end else if (ahead(m_floor, 1)) begin
                m_mode = "move"; m_dir = 1;
            end else if (ahead(m_floor, -1)) begin
                m_mode = "move"; m_dir = -1;
            end
        end else if (m_mode == "move") begin
            if (ahead(m_floor, m_dir)) begin
                m_floor += m_dir;
                if (m_pend[m_floor]) begin
                    m_mode = "door"; m_door_left = DC; nxt[m_floor] = 1'b0;
                end
            end else begin
                m_mode = "idle";
            end
        end else begin
            m_door_left--;
            if (m_door_left == 0) begin
                if (ahead(m_floor, m_dir)) m_mode = "move";
                else if (ahead(m_floor, -m_dir)) begin
                    m_mode = "move"; m_dir = -m_dir;
                end else m_mode = "idle";
            end
        end
        m_pend = nxt;
    endtask

    function automatic int status(input bit active);
        if (m_mode == "halt") return 2;
        return active ? 1 : 0;
    endfunction

    task automatic compare_all();
        int rq = 0;
        int mx = m_floor;
        int mn = m_floor;
        for (int f = 0; f < 8; f++)
            if (m_pend[f]) begin rq += (1 << f); mx = f; end
        for (int f = 7; f >= 0; f--)
            if (m_pend[f]) mn = f;
        check("floor",    int'(bus.current_floor), m_floor);
        check("requests", int'(bus.requests),      rq);
        check("max_req",  int'(bus.max_request),   mx);
        check("min_req",  int'(bus.min_request),   mn);
        check("idle",     int'(bus.idle), status(m_mode == "idle"));
        check("door",     int'(bus.door), status(m_mode == "door"));
        check("up",       int'(bus.Up),   status(m_mode == "move" && m_dir > 0));
        check("down",     int'(bus.Down), status(m_mode == "move" && m_dir < 0));
    endtask

    // Mostly re-press already-pending floors so trips complete between bursts.
    task automatic pick_inputs();
        int q[$];
        if (emg_left > 0) begin
            emg_left--;
            bus.emergency_stop = 1'b1;
        end else if ($urandom_range(99) < 4) begin
            emg_left = $urandom_range(3);
            bus.emergency_stop = 1'b1;
        end else begin
            bus.emergency_stop = 1'b0;
        end
        reset = ($urandom_range(249) == 0);
        for (int f = 0; f < 8; f++) if (m_pend[f]) q.push_back(f);
        if ($urandom_range(99) < 15 || q.size() == 0)
            bus.req_floor = 3'($urandom_range(7));
        else
            bus.req_floor = 3'(q[$urandom_range(q.size() - 1)]);
    endtask

    initial begin
        m_mode = "idle"; m_floor = 0; m_dir = 1; m_door_left = 0; emg_left = 0;
        for (int f = 0; f < 8; f++) m_pend[f] = 1'b0;
        reset              = 1'b1;
        bus.req_floor      = 3'd0;
        bus.emergency_stop = 1'b0;
        for (cyc = 0; cyc < N_CYCLES; cyc++) begin
            @(posedge clk);
            model_step(reset, int'(bus.req_floor), bus.emergency_stop);
            @(negedge clk);
            compare_all();
            pick_inputs();
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
